sram_like_resp: RTL and testbench

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

---
 rtl/sram_like_pkg.sv | 12 +
 rtl/sram_like_resp_if.sv | 24 ++
 rtl/sram_like_resp_pipe.sv | 34 +++
 rtl/sram_like_resp.sv | 81 ++++++++
 tb/tb_sram_like_resp.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_like_pkg.sv
// Shared widths and LFSR constants for the SRAM-like responder.
package sram_like_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   // Fibonacci LFSR, taps 16,14,13,11 expressed as a bit mask over state[15:0].
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sram_like_resp_if.sv
// SRAM-like request/response bus between an initiator and the responder.
interface sram_like_resp_if;
   import sram_like_pkg::*;

   logic              req;
   logic              wr;
   logic [STRB_W-1:0] wstrb;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              addr_ok;
   logic              data_ok;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wr, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );

endinterface

// File: rtl/sram_like_resp_pipe.sv
// Fixed-latency valid/data delay line; data is forced to zero in empty slots.
module sram_like_resp_pipe #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data
);

   logic [LATENCY-1:0] valid;
   logic [DATA_W-1:0]  data [LATENCY];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < LATENCY; i++) data[i] <= '0;
      end else begin
         valid[0] <= in_valid;
         data[0]  <= in_valid ? in_data : '0;
         for (int i = 1; i < LATENCY; i++) begin
            valid[i] <= valid[i-1];
            data[i]  <= data[i-1];
         end
      end
   end

   assign out_valid = valid[LATENCY-1];
   assign out_data  = data[LATENCY-1];

endmodule

// File: rtl/sram_like_resp.sv
// SRAM-like responder: byte-strobed memory, fixed-latency in-order responses.
// Define SRAM_RESP_RANDOM_STALL_EN to throttle addr_ok with a 16-bit LFSR.
module sram_like_resp
   import sram_like_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned QDEPTH     = 2
) (
   input  logic             clk,
   input  logic             rst,
   sram_like_resp_if.slave  bus
);

   localparam int unsigned WORDS = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

   logic [DATA_W-1:0]     mem [WORDS];
   logic [DEPTH_LOG2-1:0] idx;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_next;
   logic                  rdy;
   logic                  stall_ok;
   logic                  hs;
   logic [DATA_W-1:0]     resp_data;
   logic                  unused_addr;

`ifdef SRAM_RESP_RANDOM_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end

   assign stall_ok = lfsr[0];
`else
   assign stall_ok = 1'b1;
`endif

   // rdy is a register; rst only masks it so addr_ok is low throughout reset.
   assign bus.addr_ok = rdy & stall_ok & ~rst;
   assign hs          = bus.req & bus.addr_ok;
   assign idx         = bus.addr[DEPTH_LOG2+1:2];
   assign unused_addr = ^{bus.addr[ADDR_W-1:DEPTH_LOG2+2], bus.addr[1:0]};

   assign cnt_next = cnt + CNT_W'(hs) - CNT_W'(bus.data_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         rdy <= 1'b1;
      end else begin
         cnt <= cnt_next;
         rdy <= (cnt_next < CNT_W'(QDEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (hs && bus.wr) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   assign resp_data = bus.wr ? '0 : mem[idx];

   sram_like_resp_pipe #(
      .LATENCY (LATENCY),
      .DATA_W  (DATA_W)
   ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (hs),
      .in_data   (resp_data),
      .out_valid (bus.data_ok),
      .out_data  (bus.rdata)
   );

endmodule

// File: tb/tb_sram_like_resp.sv
// Directed bench for sram_like_resp across four parameter sets sharing one stimulus bus.
module tb_sram_like_resp;
   import sram_like_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  wstrb = 4'h0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        aok, dok;
   logic [31:0] rd;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_val [8];

   always #5 clk = ~clk;

   sram_like_resp_if if0 ();
   sram_like_resp_if if1 ();
   sram_like_resp_if if2 ();
   sram_like_resp_if if3 ();

   assign if0.req = req & (sel == 2'd0);
   assign if1.req = req & (sel == 2'd1);
   assign if2.req = req & (sel == 2'd2);
   assign if3.req = req & (sel == 2'd3);
   assign {if0.wr, if1.wr, if2.wr, if3.wr} = {4{wr}};
   assign {if0.wstrb, if1.wstrb, if2.wstrb, if3.wstrb} = {4{wstrb}};
   assign {if0.addr, if1.addr, if2.addr, if3.addr} = {4{addr}};
   assign {if0.wdata, if1.wdata, if2.wdata, if3.wdata} = {4{wdata}};

   assign aok = (sel == 2'd0) ? if0.addr_ok : (sel == 2'd1) ? if1.addr_ok :
                (sel == 2'd2) ? if2.addr_ok : if3.addr_ok;
   assign dok = (sel == 2'd0) ? if0.data_ok : (sel == 2'd1) ? if1.data_ok :
                (sel == 2'd2) ? if2.data_ok : if3.data_ok;
   assign rd  = (sel == 2'd0) ? if0.rdata : (sel == 2'd1) ? if1.rdata :
                (sel == 2'd2) ? if2.rdata : if3.rdata;

   sram_like_resp #(.DEPTH_LOG2(10), .LATENCY(2), .QDEPTH(2))
      u0 (.clk(clk), .rst(rst), .bus(if0.slave));
   sram_like_resp #(.DEPTH_LOG2(10), .LATENCY(3), .QDEPTH(2))
      u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   sram_like_resp #(.DEPTH_LOG2(10), .LATENCY(1), .QDEPTH(1))
      u2 (.clk(clk), .rst(rst), .bus(if2.slave));
   sram_like_resp #(.DEPTH_LOG2(4), .LATENCY(2), .QDEPTH(2))
      u3 (.clk(clk), .rst(rst), .bus(if3.slave));

   function automatic int lat_of(input logic [1:0] s);
      case (s)
         2'd1:    return 3;
         2'd2:    return 1;
         default: return 2;
      endcase
   endfunction

   function automatic int q_of(input logic [1:0] s);
      return (s == 2'd2) ? 1 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge just after the handshake edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      req = 1'b1; wr = w; addr = a; wdata = d; wstrb = s;
      for (int n = 0; n < 20 && !aok; n++) @(negedge clk);
      check("issue_aok", 32'(aok), 32'd1);
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      issue(1'b0, a, 32'h0, 4'h0);
      repeat (lat_of(sel) - 1) @(negedge clk);
      check({tag, "_ok"}, 32'(dok), 32'd1);
      check({tag, "_data"}, rd, exp);
   endtask

   task automatic preload(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         exp_val[k] = 32'h1000_0000 * 32'(k + 1) + 32'(k * 3 + 1);
         issue(1'b1, base + 32'(4 * k), exp_val[k], 4'hF);
      end
      repeat (8) @(negedge clk);
   endtask

   // req held high; model tracks outstanding count and per-request response slot.
   task automatic burst(input int n, input logic [31:0] base);
      int issued = 0;
      int resp = 0;
      int cnt = 0;
      int c = 0;
      int hs_c [8];
      logic h, exp_dok;
      int lat = lat_of(sel);
      int q = q_of(sel);
      while (resp < n && c < 60) begin
         exp_dok = (resp < issued) && (hs_c[resp] + lat == c);
         check("burst_aok", 32'(aok), 32'(cnt < q));
         check("burst_dok", 32'(dok), 32'(exp_dok));
         if (dok && resp < n) begin
            check("burst_rdata", rd, exp_val[resp]);
            resp++;
         end else begin
            check("burst_rdata_idle", rd, 32'h0);
         end
         req = (issued < n); wr = 1'b0; addr = base + 32'(4 * issued);
         h = req && aok;
         if (h) begin
            hs_c[issued] = c;
            issued++;
         end
         cnt = cnt + int'(h) - int'(dok);
         @(negedge clk);
         c++;
      end
      req = 1'b0;
      check("burst_done", 32'(resp), 32'(n));
   endtask

   initial begin
      int seen;

      repeat (3) @(negedge clk);
      check("rst_aok", 32'(aok), 32'd0);
      check("rst_dok", 32'(dok), 32'd0);
      check("rst_rdata", rd, 32'h0);
      rst = 1'b0;
      #1 check("post_rst_aok", 32'(aok), 32'd1);

      // Write then read same word back-to-back.
      req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'h1122_3344; wstrb = 4'hF;
      check("wr37_aok", 32'(aok), 32'd1);
      @(negedge clk);
      wr = 1'b0;
      check("wr37_not_early", 32'(dok), 32'd0);
      @(negedge clk);
      req = 1'b0;
      check("wr37_dok", 32'(dok), 32'd1);
      check("wr37_rdata", rd, 32'h0);
      @(negedge clk);
      check("rd37_dok", 32'(dok), 32'd1);
      check("rd37_rdata", rd, 32'h1122_3344);
      @(negedge clk);
      check("idle37_dok", 32'(dok), 32'd0);
      check("idle37_rdata", rd, 32'h0);

      // Byte-strobe merge and ignored address bits.
      issue(1'b1, 32'h80, 32'hAABB_CCDD, 4'hF);
      issue(1'b1, 32'h80, 32'h0000_00EE, 4'h1);
      read_check("strb38", 32'h80, 32'hAABB_CCEE);
      read_check("alias_hi", 32'hFFFF_F083, 32'hAABB_CCEE);
      repeat (4) @(negedge clk);

      // LATENCY=3, QDEPTH=2 streaming reads.
      sel = 2'd1;
      preload(6, 32'h100);
      burst(6, 32'h100);
      repeat (4) @(negedge clk);

      // Reset with two reads in flight, one cycle before the first response.
      req = 1'b1; wr = 1'b0; addr = 32'h100;
      check("r42_aok0", 32'(aok), 32'd1);
      @(negedge clk);
      addr = 32'h104;
      check("r42_aok1", 32'(aok), 32'd1);
      @(negedge clk);
      req = 1'b0; rst = 1'b1;
      #1 check("r42_aok_in_rst", 32'(aok), 32'd0);
      @(negedge clk);
      check("r42_dok_in_rst", 32'(dok), 32'd0);
      check("r42_rdata_in_rst", rd, 32'h0);
      rst = 1'b0;
      #1 check("r42_aok_after", 32'(aok), 32'd1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         seen += int'(dok);
      end
      check("r42_flushed", 32'(seen), 32'd0);
      read_check("mem_kept", 32'h100, exp_val[0]);
      repeat (4) @(negedge clk);

      // LATENCY=1, QDEPTH=1: handshake every other cycle.
      sel = 2'd2;
      preload(4, 32'h200);
      burst(4, 32'h200);
      repeat (4) @(negedge clk);

      // DEPTH_LOG2=4 wrap.
      sel = 2'd3;
      issue(1'b1, 32'h00, 32'h0000_0005, 4'hF);
      read_check("wrap41", 32'h40, 32'h0000_0005);
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
